// File: rtl/ctrl_pkg.sv
// Shared opcodes, control encodings, FSM states and instruction decode for the multi-cycle control unit.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;

    // {ALU_Src1_Sel, ALU_Src2_Sel}
    localparam logic [1:0] ALU_RS1_RS2 = 2'b00;
    localparam logic [1:0] ALU_RS1_IMM = 2'b01;
    localparam logic [1:0] ALU_PC_IMM  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef struct packed {
        logic [1:0] src_to_reg;
        logic [1:0] alu_sel;
        logic       branch;
        logic       jump;
        logic       load;
        logic       store;
        logic       mul;
    } ctrl_t;

    function automatic ctrl_t decode_instr(input logic [6:0] opcode,
                                           input logic [6:0] funct7,
                                           input logic       mul_en);
        ctrl_t c;
        c = '0;
        case (opcode)
            R_TYPE: begin
                c.alu_sel = ALU_RS1_RS2;
                c.mul     = mul_en && (funct7 == F7_MUL);
            end
            IMM, LUI: c.alu_sel = ALU_RS1_IMM;
            LOAD: begin
                c.alu_sel    = ALU_RS1_IMM;
                c.src_to_reg = SRC_MEM;
                c.load       = 1'b1;
            end
            STORE: begin
                c.alu_sel = ALU_RS1_IMM;
                c.store   = 1'b1;
            end
            JALR: begin
                c.alu_sel    = ALU_RS1_IMM;
                c.src_to_reg = SRC_PC4;
                c.jump       = 1'b1;
            end
            JAL: begin
                c.alu_sel    = ALU_PC_IMM;
                c.src_to_reg = SRC_PC4;
                c.jump       = 1'b1;
            end
            BRANCH: begin
                c.alu_sel = ALU_PC_IMM;
                c.branch  = 1'b1;
            end
            AUIPC:   c.alu_sel = ALU_PC_IMM;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic instr_legal(input logic [6:0] opcode,
                                         input logic [6:0] funct7,
                                         input logic       mul_en);
        logic ok;
        case (opcode)
            R_TYPE: ok = (funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                         (mul_en && (funct7 == F7_MUL));
            IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a request waits without ready; expired flags the last tolerated pending cycle.
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count_reg;
    logic [TO_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear || !req || ready) begin
            count_next = '0;
        end else begin
            count_next = count_reg + TO_W'(1);
        end
    end

    // A ready on the limit cycle wins over the timeout.
    assign expired = req && !ready && (count_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle RV32I main control FSM with memory handshakes, traps and a retirement counter.
// Defining MULTICYCLE_CTRL_MUL_EN adds the Mul_Start/Mul_Done multiplier handshake.
module multicycle_main_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             EN_PC,
    input  logic [6:0]       Opcode,
    input  logic [6:0]       Funct7,
    input  logic             Imem_Ready,
    input  logic             Dmem_Ready,
    input  logic             Branch_Taken,
    output logic             Imem_Req,
    output logic             Dmem_Req,
    output logic             IR_Wr_En,
    output logic             PC_Wr_En,
    output logic             MEM_Wr_En,
    output logic             Reg_Wr_En,
    output logic [1:0]       Src_to_Reg,
    output logic             ALU_Src1_Sel,
    output logic             ALU_Src2_Sel,
    output logic             Branch,
    output logic             Jump,
    output logic             undef_instr,
    output logic             bus_err,
    output logic             Busy,
    output logic [CNT_W-1:0] Instr_Retired
`ifdef MULTICYCLE_CTRL_MUL_EN
    ,
    input  logic             Mul_Done,
    output logic             Mul_Start
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef MULTICYCLE_CTRL_MUL_EN
    localparam logic MUL_EN = 1'b1;
    logic mul_done;
    assign mul_done = Mul_Done;
`else
    localparam logic MUL_EN = 1'b0;
    logic mul_done;
    assign mul_done = 1'b0;
`endif

    state_t state_reg, state_next;
    ctrl_t  ctl_reg, ctl_next, dec;
    logic   legal;
    logic   set_undef, set_bus, in_flight;
    logic   wait_req, wait_ready, wait_clear, timer_expired;

    logic       imem_req_reg, imem_req_next;
    logic       dmem_req_reg, dmem_req_next;
    logic       mem_wr_reg, mem_wr_next;
    logic       reg_wr_reg, reg_wr_next;
    logic       pc_wr_reg, pc_wr_next;
    logic [1:0] src_reg, src_next;
    logic [1:0] alu_sel_reg, alu_sel_next;
    logic       branch_reg, branch_next;
    logic       jump_reg, jump_next;
    logic       busy_reg, busy_next;
    logic       undef_reg, bus_err_reg;
    logic [CNT_W-1:0] retired_reg;
    logic       store_done;

    assign dec   = decode_instr(Opcode, Funct7, MUL_EN);
    assign legal = instr_legal(Opcode, Funct7, MUL_EN);

    // One shared timer serves whichever handshake the current state is waiting on.
    always_comb begin
        wait_req   = 1'b0;
        wait_ready = 1'b0;
        case (state_reg)
            FETCH: begin
                wait_req   = 1'b1;
                wait_ready = Imem_Ready;
            end
            MEM: begin
                wait_req   = 1'b1;
                wait_ready = Dmem_Ready;
            end
            EXEC: begin
                wait_req   = ctl_reg.mul;
                wait_ready = mul_done;
            end
            default: begin
                wait_req   = 1'b0;
                wait_ready = 1'b0;
            end
        endcase
    end

    assign wait_clear = (state_next != state_reg);

    mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_timer (
        .clk    (CLK),
        .rst    (rst),
        .req    (wait_req),
        .ready  (wait_ready),
        .clear  (wait_clear),
        .expired(timer_expired)
    );

    always_comb begin
        state_next = state_reg;
        set_undef  = 1'b0;
        set_bus    = 1'b0;
        case (state_reg)
            IDLE: if (EN_PC) state_next = FETCH;
            FETCH: begin
                if (Imem_Ready) begin
                    state_next = DECODE;
                end else if (timer_expired) begin
                    state_next = TRAP;
                    set_bus    = 1'b1;
                end
            end
            DECODE: begin
                if (!legal) begin
                    state_next = TRAP;
                    set_undef  = 1'b1;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (ctl_reg.mul) begin
                    if (mul_done) begin
                        state_next = WB;
                    end else if (timer_expired) begin
                        state_next = TRAP;
                        set_bus    = 1'b1;
                    end
                end else if (ctl_reg.branch) begin
                    state_next = EN_PC ? FETCH : IDLE;
                end else if (ctl_reg.load || ctl_reg.store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (Dmem_Ready) begin
                    state_next = ctl_reg.store ? (EN_PC ? FETCH : IDLE) : WB;
                end else if (timer_expired) begin
                    state_next = TRAP;
                    set_bus    = 1'b1;
                end
            end
            WB:      state_next = EN_PC ? FETCH : IDLE;
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase

        // Outputs are precomputed from the next state so they leave flops directly.
        ctl_next      = (state_reg == DECODE) ? dec : ctl_reg;
        in_flight     = (state_next == EXEC) || (state_next == MEM) || (state_next == WB);
        imem_req_next = (state_next == FETCH);
        dmem_req_next = (state_next == MEM);
        mem_wr_next   = (state_next == MEM) && ctl_next.store;
        reg_wr_next   = (state_next == WB);
        pc_wr_next    = (state_next == WB) || ((state_next == EXEC) && ctl_next.branch);
        src_next      = in_flight ? ctl_next.src_to_reg : 2'b00;
        alu_sel_next  = in_flight ? ctl_next.alu_sel : 2'b00;
        branch_next   = in_flight && ctl_next.branch;
        jump_next     = in_flight && ctl_next.jump;
        busy_next     = (state_next != IDLE) && (state_next != TRAP);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ctl_reg      <= '0;
            imem_req_reg <= 1'b0;
            dmem_req_reg <= 1'b0;
            mem_wr_reg   <= 1'b0;
            reg_wr_reg   <= 1'b0;
            pc_wr_reg    <= 1'b0;
            src_reg      <= 2'b00;
            alu_sel_reg  <= 2'b00;
            branch_reg   <= 1'b0;
            jump_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            undef_reg    <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            ctl_reg      <= ctl_next;
            imem_req_reg <= imem_req_next;
            dmem_req_reg <= dmem_req_next;
            mem_wr_reg   <= mem_wr_next;
            reg_wr_reg   <= reg_wr_next;
            pc_wr_reg    <= pc_wr_next;
            src_reg      <= src_next;
            alu_sel_reg  <= alu_sel_next;
            branch_reg   <= branch_next;
            jump_reg     <= jump_next;
            busy_reg     <= busy_next;
            undef_reg    <= undef_reg || set_undef;
            bus_err_reg  <= bus_err_reg || set_bus;
        end
    end

    // Handshake strobes gate a registered request with the memory's ready.
    assign store_done = dmem_req_reg && mem_wr_reg && Dmem_Ready;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (PC_Wr_En) begin
            retired_reg <= retired_reg + CNT_W'(1);
        end
    end

`ifdef MULTICYCLE_CTRL_MUL_EN
    logic mul_start_reg;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            mul_start_reg <= 1'b0;
        end else begin
            mul_start_reg <= (state_reg == DECODE) && (state_next == EXEC) && dec.mul;
        end
    end
    assign Mul_Start = mul_start_reg;
`endif

    assign Imem_Req      = imem_req_reg;
    assign Dmem_Req      = dmem_req_reg;
    assign IR_Wr_En      = imem_req_reg && Imem_Ready;
    assign PC_Wr_En      = pc_wr_reg || store_done;
    assign MEM_Wr_En     = mem_wr_reg;
    assign Reg_Wr_En     = reg_wr_reg;
    assign Src_to_Reg    = src_reg;
    assign ALU_Src1_Sel  = alu_sel_reg[1];
    assign ALU_Src2_Sel  = alu_sel_reg[0];
    assign Branch        = branch_reg;
    assign Jump          = jump_reg;
    assign undef_instr   = undef_reg;
    assign bus_err       = bus_err_reg;
    assign Busy          = busy_reg;
    assign Instr_Retired = retired_reg;

    logic unused_inputs;
    assign unused_inputs = Branch_Taken;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Randomized transaction-level bench for multicycle_main_ctrl against a phase-count reference model.
module tb_multicycle_main_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CW      = 4;
    localparam int NEVER   = 1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_ILLEGAL} kind_e;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          EN_PC = 1'b0;
    logic [6:0]    Opcode = '0;
    logic [6:0]    Funct7 = '0;
    logic          Imem_Ready = 1'b0;
    logic          Dmem_Ready = 1'b0;
    logic          Branch_Taken = 1'b0;
    logic          Imem_Req, Dmem_Req, IR_Wr_En, PC_Wr_En, MEM_Wr_En, Reg_Wr_En;
    logic [1:0]    Src_to_Reg;
    logic          ALU_Src1_Sel, ALU_Src2_Sel, Branch, Jump, undef_instr, bus_err, Busy;
    logic [CW-1:0] Instr_Retired;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int ret_model  = 0;

    multicycle_main_ctrl #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(CW)) dut (
        .CLK(CLK), .rst(rst), .EN_PC(EN_PC), .Opcode(Opcode), .Funct7(Funct7),
        .Imem_Ready(Imem_Ready), .Dmem_Ready(Dmem_Ready), .Branch_Taken(Branch_Taken),
        .Imem_Req(Imem_Req), .Dmem_Req(Dmem_Req), .IR_Wr_En(IR_Wr_En), .PC_Wr_En(PC_Wr_En),
        .MEM_Wr_En(MEM_Wr_En), .Reg_Wr_En(Reg_Wr_En), .Src_to_Reg(Src_to_Reg),
        .ALU_Src1_Sel(ALU_Src1_Sel), .ALU_Src2_Sel(ALU_Src2_Sel), .Branch(Branch), .Jump(Jump),
        .undef_instr(undef_instr), .bus_err(bus_err), .Busy(Busy), .Instr_Retired(Instr_Retired)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic kind_e kind_of(input logic [6:0] op, input logic [6:0] f7);
        case (op)
            OP_R:                       return (f7 == 7'h00 || f7 == 7'h20) ? K_ALU : K_ILLEGAL;
            OP_IMM, OP_LUI, OP_AUIPC:   return K_ALU;
            OP_LOAD:                    return K_LOAD;
            OP_STORE:                   return K_STORE;
            OP_BRANCH:                  return K_BRANCH;
            OP_JAL, OP_JALR:            return K_JUMP;
            default:                    return K_ILLEGAL;
        endcase
    endfunction

    function automatic logic [1:0] alu_sel_of(input logic [6:0] op);
        case (op)
            OP_R:                          return 2'b00;
            OP_BRANCH, OP_JAL, OP_AUIPC:   return 2'b11;
            default:                       return 2'b01;
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return {16'h0, Imem_Req, Dmem_Req, IR_Wr_En, PC_Wr_En, MEM_Wr_En, Reg_Wr_En,
                Src_to_Reg, ALU_Src1_Sel, ALU_Src2_Sel, Branch, Jump, undef_instr,
                bus_err, Busy, 1'b0};
    endfunction

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic reset_check(input string tag);
        #1 rst = 1'b1;
        #1;
        check_eq({tag, "_outs"}, all_outs(), 32'h0);
        check_eq({tag, "_retired"}, 32'(Instr_Retired), 32'h0);
        EN_PC = 1'b0;
        Imem_Ready = 1'b0;
        Dmem_Ready = 1'b0;
        @(negedge CLK) rst = 1'b0;
        @(posedge CLK);
        #1;
        ret_model = 0;
    endtask

    task automatic sticky_check(input logic exp_undef, input logic exp_bus);
        for (int i = 0; i < 6; i++) begin
            EN_PC = i[0];
            @(posedge CLK);
            #1;
            check_eq("sticky_flags", {30'h0, undef_instr, bus_err}, {30'h0, exp_undef, exp_bus});
            check_eq("sticky_idle", {30'h0, Busy, Imem_Req}, 32'h0);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input int imem_dly,
                             input int dmem_dly, input logic taken, input logic chain,
                             input int abort_at);
        kind_e      k;
        int         cyc, n_ireq, n_ir, n_dreq, n_mwr, n_rw, n_pc, n_bad, exp_cyc;
        logic       stop, saw_branch, saw_jump, exp_trap_bus, exp_trap_undef;
        logic [1:0] src_seen, alu_seen;
        k = kind_of(op, f7);
        cyc = 0; n_ireq = 0; n_ir = 0; n_dreq = 0; n_mwr = 0; n_rw = 0; n_pc = 0; n_bad = 0;
        stop = 1'b0; saw_branch = 1'b0; saw_jump = 1'b0; src_seen = 2'b00; alu_seen = 2'b00;
        Opcode = op;
        Funct7 = f7;
        Branch_Taken = taken;
        if (!Busy) begin
            EN_PC = 1'b1;
            @(posedge CLK);
            #1;
        end
        EN_PC = chain;
        while (!stop && cyc < 80) begin
            Imem_Ready = Imem_Req && (n_ireq >= imem_dly);
            Dmem_Ready = Dmem_Req && (n_dreq >= dmem_dly);
            #1;
            cyc++;
            if (Imem_Req)  n_ireq++;
            if (IR_Wr_En)  n_ir++;
            if (Dmem_Req)  n_dreq++;
            if (MEM_Wr_En) n_mwr++;
            if (Branch)    saw_branch = 1'b1;
            if (Jump)      saw_jump = 1'b1;
            if (Reg_Wr_En) begin
                n_rw++;
                src_seen = Src_to_Reg;
            end
            if (PC_Wr_En) begin
                n_pc++;
                alu_seen = {ALU_Src1_Sel, ALU_Src2_Sel};
            end
            if (Imem_Req && (Reg_Wr_En || MEM_Wr_En || PC_Wr_En)) n_bad++;
            stop = PC_Wr_En || undef_instr || bus_err || (abort_at > 0 && cyc == abort_at);
            if (!stop) begin
                @(posedge CLK);
                #1;
            end
        end
        if (abort_at > 0) begin
            $display("TXN op=%b f7=%b aborted at cycle %0d", op, f7, cyc);
            return;
        end
        check_eq("finished_in_budget", {31'h0, stop}, 32'h1);

        exp_trap_bus   = (imem_dly >= TIMEOUT) ||
                         (k != K_ILLEGAL && (k == K_LOAD || k == K_STORE) && dmem_dly >= TIMEOUT);
        exp_trap_undef = !exp_trap_bus && (k == K_ILLEGAL);
        if (imem_dly >= TIMEOUT)  exp_cyc = TIMEOUT + 1;
        else if (exp_trap_undef)  exp_cyc = imem_dly + 3;
        else if (exp_trap_bus)    exp_cyc = imem_dly + 3 + TIMEOUT + 1;
        else if (k == K_BRANCH)   exp_cyc = imem_dly + 3;
        else if (k == K_STORE)    exp_cyc = imem_dly + 3 + dmem_dly + 1;
        else if (k == K_LOAD)     exp_cyc = imem_dly + 3 + dmem_dly + 2;
        else                      exp_cyc = imem_dly + 4;

        check_eq("cycles", cyc, exp_cyc);
        check_eq("trap_flags", {30'h0, undef_instr, bus_err}, {30'h0, exp_trap_undef, exp_trap_bus});
        check_eq("no_wr_in_fetch", n_bad, 0);
        check_eq("ir_pulses", n_ir, (imem_dly >= TIMEOUT) ? 0 : 1);
        check_eq("imem_req_cycles", n_ireq, (imem_dly >= TIMEOUT) ? TIMEOUT : imem_dly + 1);

        if (exp_trap_bus || exp_trap_undef) begin
            check_eq("trap_no_retire", n_pc + n_rw, 0);
            check_eq("trap_busy", {31'h0, Busy}, 32'h0);
            if (exp_trap_bus && imem_dly < TIMEOUT)
                check_eq("dmem_req_timeout", n_dreq, TIMEOUT);
        end else begin
            check_eq("pc_wr_once", n_pc, 1);
            check_eq("reg_wr", n_rw, (k == K_STORE || k == K_BRANCH) ? 0 : 1);
            check_eq("dmem_req_cycles", n_dreq, (k == K_LOAD || k == K_STORE) ? dmem_dly + 1 : 0);
            check_eq("mem_wr_cycles", n_mwr, (k == K_STORE) ? dmem_dly + 1 : 0);
            check_eq("branch_flag", {31'h0, saw_branch}, {31'h0, k == K_BRANCH});
            check_eq("jump_flag", {31'h0, saw_jump}, {31'h0, k == K_JUMP});
            check_eq("alu_sel", {30'h0, alu_seen}, {30'h0, alu_sel_of(op)});
            if (n_rw > 0)
                check_eq("src_to_reg", {30'h0, src_seen},
                         (k == K_LOAD) ? 32'h1 : (k == K_JUMP) ? 32'h2 : 32'h0);
            @(posedge CLK);
            #1;
            Imem_Ready = 1'b0;
            Dmem_Ready = 1'b0;
            ret_model = (ret_model + 1) % (1 << CW);
            check_eq("retired", 32'(Instr_Retired), ret_model);
            check_eq("after_busy", {30'h0, Busy, Imem_Req}, {30'h0, chain, chain});
            check_eq("after_quiet", {28'h0, Reg_Wr_En, PC_Wr_En, MEM_Wr_En, Dmem_Req}, 32'h0);
        end
        $display("TXN op=%b f7=%b idly=%0d ddly=%0d chain=%0b cyc=%0d retired=%0d undef=%0b bus=%0b",
                 op, f7, imem_dly, dmem_dly, chain, cyc, Instr_Retired, undef_instr, bus_err);
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] bad_ops   [3];
    logic [6:0] bad_f7    [3];

    initial begin
        legal_ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        bad_ops   = '{7'b1111111, 7'b0000000, 7'b0001011};
        bad_f7    = '{7'b0000001, 7'b0000010, 7'b1111111};

        @(posedge CLK);
        #1;
        check_eq("reset_outs", all_outs(), 32'h0);
        check_eq("reset_retired", 32'(Instr_Retired), 32'h0);
        @(negedge CLK) rst = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("idle_outs", all_outs(), 32'h0);

        run_instr(OP_IMM,    7'h00, 0, 0,     1'b0, 1'b0, 0);
        run_instr(OP_LOAD,   7'h00, 0, 3,     1'b0, 1'b1, 0);
        run_instr(OP_BRANCH, 7'h00, 1, 0,     1'b1, 1'b1, 0);
        run_instr(OP_BRANCH, 7'h00, 0, 0,     1'b0, 1'b0, 0);
        run_instr(OP_JAL,    7'h00, 2, 0,     1'b0, 1'b0, 0);
        run_instr(7'b1111111, 7'h00, 0, 0,    1'b0, 1'b0, 0);
        sticky_check(1'b1, 1'b0);
        reset_check("rst_undef");
        run_instr(OP_R,      7'b0000010, 0, 0, 1'b0, 1'b0, 0);
        sticky_check(1'b1, 1'b0);
        reset_check("rst_funct7");
        run_instr(OP_STORE,  7'h00, 0, NEVER, 1'b0, 1'b0, 0);
        sticky_check(1'b0, 1'b1);
        reset_check("rst_bus");
        run_instr(OP_STORE,  7'h00, 0, TIMEOUT - 1, 1'b0, 1'b0, 0);
        run_instr(OP_IMM,    7'h00, NEVER, 0, 1'b0, 1'b0, 0);
        reset_check("rst_ibus");
        run_instr(OP_LOAD,   7'h00, 0, NEVER, 1'b0, 1'b0, 8);
        check_eq("mid_mem_req", {31'h0, Dmem_Req}, 32'h1);
        reset_check("rst_mid_mem");
        run_instr(OP_LOAD,   7'h00, 0, TIMEOUT - 1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 18; i++) begin
            run_instr(OP_IMM, 7'h00, 0, 0, 1'b0, 1'b1, 0);
        end
        run_instr(OP_LUI, 7'h00, 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            int          r;
            logic [6:0]  op, f7;
            int          idly, ddly;
            r    = $urandom_range(0, 19);
            op   = legal_ops[$urandom_range(0, 8)];
            f7   = 7'($urandom);
            idly = $urandom_range(0, 4);
            ddly = $urandom_range(0, 5);
            if (op == OP_R) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (r == 0) begin
                op = bad_ops[$urandom_range(0, 2)];
            end else if (r == 1) begin
                op = OP_R;
                f7 = bad_f7[$urandom_range(0, 2)];
            end else if (r == 2) begin
                idly = NEVER;
            end else if (r == 3) begin
                op   = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
                ddly = NEVER;
            end else if (r == 4) begin
                ddly = TIMEOUT - 1;
            end
            run_instr(op, f7, idly, ddly, 1'($urandom), 1'($urandom), 0);
            if (undef_instr || bus_err || r == 2 || r == 3 || kind_of(op, f7) == K_ILLEGAL)
                reset_check("rst_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
